cell_mem_arbiter: RTL and testbench
===================================

CELL_MEM_ARBITER -- requirements
Module: cell_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, cell-memory word address width.
REQ-002 Parameter DATA_WIDTH, default 32, cell-memory word width (one bit per cell).
REQ-003 Parameter READ_LATENCY, default 2, cycles from mem_en_out high to mem_rdata_in valid; legal range 1..4.
REQ-004 Parameter STARVE_LIMIT, default 8, consecutive denied editor-request cycles before the editor is boosted; legal range 2..255.
REQ-005 The port list SHALL be:
clk_in  in  1  sole clock, all state on rising edge
rst_n_in  in  1  reset, asynchronous, active-low
hold_in  in  1  buffer-swap freeze from the frame synchronizer
rend_req_in  in  1  renderer read request
rend_addr_in  in  ADDR_WIDTH  renderer read address
rend_gnt_out  out  1  renderer request accepted this cycle
rend_valid_out  out  1  renderer read data valid
logic_req_in  in  1  logic-engine request
logic_we_in  in  1  logic-engine write (1) / read (0)
logic_addr_in  in  ADDR_WIDTH  logic-engine address
logic_wdata_in  in  DATA_WIDTH  logic-engine write data
logic_gnt_out  out  1  logic request accepted this cycle
logic_valid_out  out  1  logic read data valid
edit_req_in  in  1  cursor-editor request
edit_we_in  in  1  editor write (1) / read (0)
edit_addr_in  in  ADDR_WIDTH  editor address
edit_wdata_in  in  DATA_WIDTH  editor write data
edit_gnt_out  out  1  editor request accepted this cycle
edit_valid_out  out  1  editor read data valid
rdata_out  out  DATA_WIDTH  read data, shared by all three valid strobes
mem_en_out, mem_we_out  out  1  memory enable / write enable
mem_addr_out  out  ADDR_WIDTH  memory address
mem_wdata_out  out  DATA_WIDTH  memory write data
mem_rdata_in  in  DATA_WIDTH  memory read data
idle_out  out  1  no transaction in flight, no grant this cycle

Function
REQ-006 Grants SHALL be combinational from current inputs and registered state; at most one gnt_out high per cycle; a request is accepted in the cycle where req and gnt are both high.
REQ-007 Priority SHALL be renderer > logic > editor; when the editor is boosted, order SHALL be renderer > editor > logic.
REQ-008 Starve counter: increments (saturating at STARVE_LIMIT) each cycle edit_req_in is high and edit_gnt_out low; clears when the editor is granted or edit_req_in is low; editor boosted while counter == STARVE_LIMIT.
REQ-009 While hold_in is high, and for the one cycle after it falls, no gnt_out SHALL assert; the starve counter SHALL hold its value.
REQ-010 An accepted request in cycle T SHALL appear on mem_en_out=1, mem_we_out, mem_addr_out, mem_wdata_out registered in cycle T+1; in cycles without acceptance mem_en_out and mem_we_out SHALL be 0.
REQ-011 Accepted reads SHALL carry a 2-bit requester tag through a READ_LATENCY+1-stage pipeline; at T+2+READ_LATENCY the matching valid_out SHALL pulse for one cycle with rdata_out = registered mem_rdata_in.
REQ-012 Accepted writes SHALL produce no valid_out pulse.
REQ-013 Read responses SHALL return in acceptance order; back-to-back accepts every cycle SHALL be sustained (throughput 1 per cycle).
REQ-014 idle_out SHALL be high only when no gnt_out is high, mem_en_out is low and the tag pipeline holds no read.
REQ-015 Requests held high across cycles without grant SHALL not be dropped or duplicated; each accept is exactly one memory access.

Reset
REQ-016 rst_n_in low SHALL immediately force all gnt_out, valid_out, mem_en_out, mem_we_out to 0, mem_addr_out, mem_wdata_out, rdata_out to 0, starve counter and tag pipeline to 0, idle_out to 1.
REQ-017 Reads in flight when reset asserts SHALL be discarded; no valid_out pulse after reset release.
REQ-018 Reset release SHALL be consumed synchronously; first grant possible on the first rising edge with rst_n_in high.

Verification
REQ-019 Renderer read addr 0x010, READ_LATENCY=2, accepted T=5 -> mem_en_out/addr 0x010 at T=6; rend_valid_out with rdata_out=mem_rdata_in at T=9.
REQ-020 Renderer and logic request together for 3 cycles -> rend_gnt_out 3 cycles, logic_gnt_out 0; logic granted cycle 4 when renderer drops.
REQ-021 Logic requests continuously, editor requests from T=0, STARVE_LIMIT=8 -> edit_gnt_out first high at T=8, counter then 0, logic regranted T=9.
REQ-022 hold_in high T=10..14 with all requests high -> no grant T=10..15; renderer granted T=16; idle_out high once pipeline drains.
REQ-023 Logic read accepted T=3, rst_n_in low T=4..5 -> all outputs 0 immediately, no logic_valid_out ever for that read.
REQ-024 Alternating logic writes and editor reads every cycle -> one mem access per cycle, edit_valid_out count equals editor read accepts, zero logic_valid_out.

Source files
------------

// File: rtl/cell_mem_arbiter.sv
// Three-way arbiter that shares one cell memory between the renderer, the logic engine and the cursor editor.
// Grants are combinational. Read responses return in acceptance order via a requester-tag pipeline.
module cell_mem_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  hold_in,
  input  logic                  rend_req_in,
  input  logic [ADDR_WIDTH-1:0] rend_addr_in,
  output logic                  rend_gnt_out,
  output logic                  rend_valid_out,
  input  logic                  logic_req_in,
  input  logic                  logic_we_in,
  input  logic [ADDR_WIDTH-1:0] logic_addr_in,
  input  logic [DATA_WIDTH-1:0] logic_wdata_in,
  output logic                  logic_gnt_out,
  output logic                  logic_valid_out,
  input  logic                  edit_req_in,
  input  logic                  edit_we_in,
  input  logic [ADDR_WIDTH-1:0] edit_addr_in,
  input  logic [DATA_WIDTH-1:0] edit_wdata_in,
  output logic                  edit_gnt_out,
  output logic                  edit_valid_out,
  output logic [DATA_WIDTH-1:0] rdata_out,
  output logic                  mem_en_out,
  output logic                  mem_we_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [DATA_WIDTH-1:0] mem_wdata_out,
  input  logic [DATA_WIDTH-1:0] mem_rdata_in,
  output logic                  idle_out
);

  typedef enum logic [1:0] {
    TAG_NONE  = 2'b00,
    TAG_REND  = 2'b01,
    TAG_LOGIC = 2'b10,
    TAG_EDIT  = 2'b11
  } tag_t;

  localparam logic [7:0] LP_LIMIT = 8'(STARVE_LIMIT);

  logic                  r_hold_d;
  logic [7:0]            r_starve;
  tag_t                  r_tag [0:READ_LATENCY];
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_rend_valid;
  logic                  r_logic_valid;
  logic                  r_edit_valid;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_block;
  logic                  w_boost;
  logic                  w_rend_gnt;
  logic                  w_logic_gnt;
  logic                  w_edit_gnt;
  logic                  w_acc;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  tag_t                  w_tag;
  logic                  w_pipe_busy;

  // Grants are blocked during a swap freeze and for one cycle after it ends.
  assign w_block = hold_in | r_hold_d;
  assign w_boost = (r_starve == LP_LIMIT);

  // Priority select. A boosted editor jumps ahead of the logic engine, never the renderer.
  always_comb begin
    w_rend_gnt  = 1'b0;
    w_logic_gnt = 1'b0;
    w_edit_gnt  = 1'b0;
    if (rst_n_in && !w_block) begin
      if (rend_req_in) begin
        w_rend_gnt = 1'b1;
      end else if (w_boost && edit_req_in) begin
        w_edit_gnt = 1'b1;
      end else if (logic_req_in) begin
        w_logic_gnt = 1'b1;
      end else if (edit_req_in) begin
        w_edit_gnt = 1'b1;
      end else begin
        w_rend_gnt = 1'b0;
      end
    end else begin
      w_rend_gnt = 1'b0;
    end
  end

  // Steer the accepted requester's command toward the memory port.
  always_comb begin
    w_acc   = 1'b0;
    w_we    = 1'b0;
    w_addr  = {ADDR_WIDTH{1'b0}};
    w_wdata = {DATA_WIDTH{1'b0}};
    w_tag   = TAG_NONE;
    if (w_rend_gnt) begin
      w_acc  = 1'b1;
      w_addr = rend_addr_in;
      w_tag  = TAG_REND;
    end else if (w_logic_gnt) begin
      w_acc   = 1'b1;
      w_we    = logic_we_in;
      w_addr  = logic_addr_in;
      w_wdata = logic_wdata_in;
      w_tag   = TAG_LOGIC;
    end else if (w_edit_gnt) begin
      w_acc   = 1'b1;
      w_we    = edit_we_in;
      w_addr  = edit_addr_in;
      w_wdata = edit_wdata_in;
      w_tag   = TAG_EDIT;
    end else begin
      w_acc = 1'b0;
    end
  end

  // Tracks the freeze and the editor starvation count. The count holds while grants are blocked.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_hold_d <= 1'b0;
      r_starve <= 8'd0;
    end else begin
      r_hold_d <= hold_in;
      if (w_block) begin
        r_starve <= r_starve;
      end else if (edit_req_in && !w_edit_gnt) begin
        r_starve <= (r_starve == LP_LIMIT) ? r_starve : r_starve + 8'd1;
      end else begin
        r_starve <= 8'd0;
      end
    end
  end

  // Registered memory command. The address and data hold when no request is accepted.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {ADDR_WIDTH{1'b0}};
      r_mem_wdata <= {DATA_WIDTH{1'b0}};
    end else begin
      r_mem_en <= w_acc;
      r_mem_we <= w_acc & w_we;
      if (w_acc) begin
        r_mem_addr  <= w_addr;
        r_mem_wdata <= w_wdata;
      end else begin
        r_mem_addr  <= r_mem_addr;
        r_mem_wdata <= r_mem_wdata;
      end
    end
  end

  // The tag for a read reaches the last stage in the same cycle that the memory returns its data.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int k = 0; k <= READ_LATENCY; k++) begin
        r_tag[k] <= TAG_NONE;
      end
    end else begin
      r_tag[0] <= (w_acc && !w_we) ? w_tag : TAG_NONE;
      for (int k = 1; k <= READ_LATENCY; k++) begin
        r_tag[k] <= r_tag[k-1];
      end
    end
  end

  // Response stage: capture the read data and pulse the valid strobe of the owning requester.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rend_valid  <= 1'b0;
      r_logic_valid <= 1'b0;
      r_edit_valid  <= 1'b0;
      r_rdata       <= {DATA_WIDTH{1'b0}};
    end else begin
      r_rend_valid  <= (r_tag[READ_LATENCY] == TAG_REND);
      r_logic_valid <= (r_tag[READ_LATENCY] == TAG_LOGIC);
      r_edit_valid  <= (r_tag[READ_LATENCY] == TAG_EDIT);
      if (r_tag[READ_LATENCY] != TAG_NONE) begin
        r_rdata <= mem_rdata_in;
      end else begin
        r_rdata <= r_rdata;
      end
    end
  end

  // True while any read is still in flight through the tag pipeline.
  always_comb begin
    w_pipe_busy = 1'b0;
    for (int k = 0; k <= READ_LATENCY; k++) begin
      w_pipe_busy = w_pipe_busy | (r_tag[k] != TAG_NONE);
    end
  end

  assign rend_gnt_out    = w_rend_gnt;
  assign logic_gnt_out   = w_logic_gnt;
  assign edit_gnt_out    = w_edit_gnt;
  assign rend_valid_out  = r_rend_valid;
  assign logic_valid_out = r_logic_valid;
  assign edit_valid_out  = r_edit_valid;
  assign rdata_out       = r_rdata;
  assign mem_en_out      = r_mem_en;
  assign mem_we_out      = r_mem_we;
  assign mem_addr_out    = r_mem_addr;
  assign mem_wdata_out   = r_mem_wdata;
  assign idle_out        = ~w_acc & ~r_mem_en & ~w_pipe_busy;

endmodule

// File: tb/tb_cell_mem_arbiter.sv
// Directed testbench for cell_mem_arbiter. It uses the default parameters and a two-cycle memory model.
// The memory model returns a fixed pattern derived from the address.
module tb_cell_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        hold_in;
  logic        rend_req_in;
  logic [11:0] rend_addr_in;
  logic        rend_gnt_out, rend_valid_out;
  logic        logic_req_in, logic_we_in;
  logic [11:0] logic_addr_in;
  logic [31:0] logic_wdata_in;
  logic        logic_gnt_out, logic_valid_out;
  logic        edit_req_in, edit_we_in;
  logic [11:0] edit_addr_in;
  logic [31:0] edit_wdata_in;
  logic        edit_gnt_out, edit_valid_out;
  logic [31:0] rdata_out;
  logic        mem_en_out, mem_we_out;
  logic [11:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic [31:0] mem_rdata_in;
  logic        idle_out;

  logic [31:0] r_sh0, r_sh1;
  int n_tests = 0;
  int n_fail  = 0;
  int cnt_en, cnt_we, cnt_ev, cnt_lv, cnt_rv;

  cell_mem_arbiter dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .hold_in(hold_in),
    .rend_req_in(rend_req_in), .rend_addr_in(rend_addr_in),
    .rend_gnt_out(rend_gnt_out), .rend_valid_out(rend_valid_out),
    .logic_req_in(logic_req_in), .logic_we_in(logic_we_in),
    .logic_addr_in(logic_addr_in), .logic_wdata_in(logic_wdata_in),
    .logic_gnt_out(logic_gnt_out), .logic_valid_out(logic_valid_out),
    .edit_req_in(edit_req_in), .edit_we_in(edit_we_in),
    .edit_addr_in(edit_addr_in), .edit_wdata_in(edit_wdata_in),
    .edit_gnt_out(edit_gnt_out), .edit_valid_out(edit_valid_out),
    .rdata_out(rdata_out), .mem_en_out(mem_en_out), .mem_we_out(mem_we_out),
    .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
    .mem_rdata_in(mem_rdata_in), .idle_out(idle_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] mdata(input logic [11:0] a);
    return {20'hC0DE0, a};
  endfunction

  // Memory model: data for the address presented in cycle C is on mem_rdata_in in cycle C+2.
  always @(posedge clk_in) begin
    r_sh0 <= mdata(mem_addr_out);
    r_sh1 <= r_sh0;
  end
  assign mem_rdata_in = r_sh1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [31:0] gnts();
    return {29'd0, rend_gnt_out, logic_gnt_out, edit_gnt_out};
  endfunction

  initial begin
    rst_n_in = 1'b0; hold_in = 1'b0;
    rend_req_in = 1'b0; rend_addr_in = 12'h000;
    logic_req_in = 1'b0; logic_we_in = 1'b0; logic_addr_in = 12'h000; logic_wdata_in = 32'h0;
    edit_req_in = 1'b0; edit_we_in = 1'b0; edit_addr_in = 12'h000; edit_wdata_in = 32'h0;
    #2;
    chk("rst_idle", idle_out, 1'b1);
    chk("rst_mem_en", mem_en_out, 1'b0);
    chk("rst_mem_addr", mem_addr_out, 12'h000);
    chk("rst_rdata", rdata_out, 32'h0);
    rend_req_in = 1'b1;
    #1;
    chk("rst_gnt_blocked", gnts(), 32'd0);
    rend_req_in = 1'b0;
    tick; tick;
    rst_n_in = 1'b1;
    tick;

    // Single renderer read: command at +1, response at +4.
    rend_req_in = 1'b1; rend_addr_in = 12'h010;
    #1;
    chk("r1_gnt", gnts(), 32'd4);
    chk("r1_idle_busy", idle_out, 1'b0);
    tick; rend_req_in = 1'b0; #1;
    chk("r1_mem_en", mem_en_out, 1'b1);
    chk("r1_mem_we", mem_we_out, 1'b0);
    chk("r1_mem_addr", mem_addr_out, 12'h010);
    tick; #1;
    chk("r1_mem_en_off", mem_en_out, 1'b0);
    tick; #1;
    chk("r1_valid_early", rend_valid_out, 1'b0);
    tick; #1;
    chk("r1_valid", rend_valid_out, 1'b1);
    chk("r1_rdata", rdata_out, mdata(12'h010));
    tick; #1;
    chk("r1_valid_end", rend_valid_out, 1'b0);
    chk("r1_idle", idle_out, 1'b1);

    // Renderer beats logic for 3 cycles; logic wins when the renderer drops; responses stay in order.
    tick;
    rend_req_in = 1'b1; logic_req_in = 1'b1; logic_we_in = 1'b0; logic_addr_in = 12'h020;
    for (int i = 0; i < 3; i++) begin
      rend_addr_in = 12'h030 + 12'(i);
      #1;
      chk("r2_rend_wins", gnts(), 32'd4);
      tick;
    end
    rend_req_in = 1'b0;
    #1;
    chk("r2_logic_gnt", gnts(), 32'd2);
    tick; logic_req_in = 1'b0; #1;
    chk("r2_mem_addr", mem_addr_out, 12'h020);
    chk("r2_rv0", rend_valid_out, 1'b1);
    chk("r2_rd0", rdata_out, mdata(12'h030));
    tick; #1;
    chk("r2_rd1", rdata_out, mdata(12'h031));
    tick; #1;
    chk("r2_rd2", rdata_out, mdata(12'h032));
    tick; #1;
    chk("r2_lv", logic_valid_out, 1'b1);
    chk("r2_rv_off", rend_valid_out, 1'b0);
    chk("r2_ld", rdata_out, mdata(12'h020));
    tick; tick;

    // A starved editor is boosted after 8 denied cycles.
    logic_req_in = 1'b1; logic_we_in = 1'b1; logic_addr_in = 12'h0AA;
    edit_req_in = 1'b1; edit_we_in = 1'b0; edit_addr_in = 12'h040;
    for (int k = 0; k < 10; k++) begin
      logic_wdata_in = 32'h1000_0000 + 32'(k);
      #1;
      if (k == 8) begin
        chk("s_edit_boost", gnts(), 32'd1);
        chk("s_wdata", mem_wdata_out, 32'h1000_0007);
        chk("s_we", mem_we_out, 1'b1);
      end else begin
        chk("s_logic_gnt", gnts(), 32'd2);
      end
      if (k == 9) begin
        chk("s_edit_mem_we", mem_we_out, 1'b0);
        chk("s_edit_mem_addr", mem_addr_out, 12'h040);
      end
      tick;
    end
    logic_req_in = 1'b0; edit_req_in = 1'b0;
    tick; #1;
    chk("s_ev_early", edit_valid_out, 1'b0);
    tick; #1;
    chk("s_ev", edit_valid_out, 1'b1);
    chk("s_ed", rdata_out, mdata(12'h040));
    tick; tick; tick;

    // Swap freeze blocks grants for the freeze plus one cycle.
    hold_in = 1'b1; rend_req_in = 1'b1; rend_addr_in = 12'h070;
    logic_req_in = 1'b1; logic_we_in = 1'b0; edit_req_in = 1'b1;
    #1;
    chk("h_idle", idle_out, 1'b1);
    for (int h = 0; h < 5; h++) begin
      if (h > 0) #1;
      chk("h_no_gnt", gnts(), 32'd0);
      tick;
    end
    hold_in = 1'b0;
    #1;
    chk("h_tail_no_gnt", gnts(), 32'd0);
    tick; #1;
    chk("h_rend_gnt", gnts(), 32'd4);
    tick;
    rend_req_in = 1'b0; logic_req_in = 1'b0; edit_req_in = 1'b0;
    tick; tick; tick; #1;
    chk("h_rv", rend_valid_out, 1'b1);
    chk("h_rd", rdata_out, mdata(12'h070));
    tick; #1;
    chk("h_idle_drained", idle_out, 1'b1);

    // Reset with a logic read in flight: it is dropped, and a grant is possible right after release.
    tick;
    logic_req_in = 1'b1; logic_we_in = 1'b0; logic_addr_in = 12'h050;
    #1;
    chk("x_logic_gnt", gnts(), 32'd2);
    tick;
    logic_req_in = 1'b0; rend_req_in = 1'b1; rst_n_in = 1'b0;
    #1;
    chk("x_mem_en", mem_en_out, 1'b0);
    chk("x_mem_addr", mem_addr_out, 12'h000);
    chk("x_gnt", gnts(), 32'd0);
    chk("x_idle", idle_out, 1'b1);
    tick; tick;
    rst_n_in = 1'b1; rend_addr_in = 12'h060;
    #1;
    chk("x_first_gnt", gnts(), 32'd4);
    tick;
    rend_req_in = 1'b0;
    cnt_lv = 0; cnt_rv = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      cnt_lv += int'(logic_valid_out);
      cnt_rv += int'(rend_valid_out);
      tick;
    end
    chk("x_no_lv", cnt_lv, 32'd0);
    chk("x_one_rv", cnt_rv, 32'd1);

    // Alternating logic writes and editor reads, one access per cycle.
    cnt_en = 0; cnt_we = 0; cnt_ev = 0; cnt_lv = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < 8 && (i % 2) == 0) begin
        logic_req_in = 1'b1; logic_we_in = 1'b1;
        logic_addr_in = 12'h100 + 12'(i); logic_wdata_in = 32'hBEEF_0000 + 32'(i);
        edit_req_in = 1'b0;
      end else if (i < 8) begin
        logic_req_in = 1'b0;
        edit_req_in = 1'b1; edit_we_in = 1'b0; edit_addr_in = 12'h200 + 12'(i);
      end else begin
        logic_req_in = 1'b0; edit_req_in = 1'b0;
      end
      #1;
      cnt_en += int'(mem_en_out);
      cnt_we += int'(mem_we_out);
      cnt_ev += int'(edit_valid_out);
      cnt_lv += int'(logic_valid_out);
      if (i < 8) begin
        chk("a_gnt", gnts(), ((i % 2) == 0) ? 32'd2 : 32'd1);
      end
      tick;
    end
    chk("a_mem_en_cnt", cnt_en, 32'd8);
    chk("a_mem_we_cnt", cnt_we, 32'd4);
    chk("a_ev_cnt", cnt_ev, 32'd4);
    chk("a_lv_cnt", cnt_lv, 32'd0);
    #1;
    chk("a_idle", idle_out, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
